// File: rtl/sram_arb_pkg.sv
// Shared types and default bus widths for the SRAM port arbiter and the
// pipeline blocks around it.
package sram_arb_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 128;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } sram_op_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    function automatic int unsigned wrap_inc(int unsigned idx, int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester-side bus and SRAM-side bus of the port arbiter.
interface sram_port_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = sram_arb_pkg::ADDR_W,
    parameter int DATA_W  = sram_arb_pkg::DATA_W
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        we;
    logic [NUM_REQ-1:0]        lock;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]         rdata;
    logic                      busy;

    modport master (output req, we, lock, addr, wdata, input gnt, rvalid, rdata, busy);
    modport slave  (input req, we, lock, addr, wdata, output gnt, rvalid, rdata, busy);
endinterface

interface sram_mem_if #(
    parameter int ADDR_W = sram_arb_pkg::ADDR_W,
    parameter int DATA_W = sram_arb_pkg::DATA_W
);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [ADDR_W-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output mem_we, mem_waddr, mem_wdata, mem_raddr, input mem_rdata);
    modport slave  (input mem_we, mem_waddr, mem_wdata, mem_raddr, output mem_rdata);
endinterface

// File: rtl/sram_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after rr_ptr, wrapping.
module rr_pick #(
    parameter int  NUM_REQ = 4,
    localparam int PTR_W   = $clog2(NUM_REQ),
    localparam int CW      = PTR_W + 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   winner,
    output logic               any
);
    logic [CW-1:0] cand;

    always_comb begin
        gnt    = '0;
        winner = '0;
        any    = 1'b0;
        cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + CW'(k);
            if (cand >= CW'(NUM_REQ)) begin
                cand = cand - CW'(NUM_REQ);
            end
            if (!any && req[cand[PTR_W-1:0]]) begin
                any                    = 1'b1;
                winner                 = cand[PTR_W-1:0];
                gnt[cand[PTR_W-1:0]]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one sram_2R1W write port and read port 1 between NUM_REQ requesters,
// one transfer per clock, with optional lock for bursts and pipelined read return.
//
//   state  | meaning
//   IDLE   | round-robin arbitration from rr_ptr
//   LOCKED | owner alone may transfer; a cycle without req[owner] releases
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_W       = sram_arb_pkg::ADDR_W,
    parameter int DATA_W       = sram_arb_pkg::DATA_W,
    parameter int READ_LATENCY = 1
) (
    input  logic               clock,
    input  logic               rst,
    sram_port_arbiter_if.slave rq,
    sram_mem_if.master         mem
);
    localparam int PTR_W = $clog2(NUM_REQ);

    arb_state_t              state_q, state_d;
    logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]        owner_q, owner_d;
    logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [PTR_W-1:0]        pipe_id_q [READ_LATENCY];
    logic [PTR_W-1:0]        pipe_id_d [READ_LATENCY];
    logic [ADDR_W-1:0]       waddr_q, waddr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;

    logic [NUM_REQ-1:0] pick_gnt, gnt;
    logic [PTR_W-1:0]   pick_idx, sel;
    logic               pick_any, xfer, wr, rd;
    sram_op_t           op;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req    (rq.req),
        .rr_ptr (rr_ptr_q),
        .gnt    (pick_gnt),
        .winner (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        sel  = pick_idx;
        gnt  = pick_gnt;
        xfer = pick_any;
        if (state_q == LOCKED) begin
            sel          = owner_q;
            gnt          = '0;
            gnt[owner_q] = rq.req[owner_q];
            xfer         = rq.req[owner_q];
        end
        if (rst) begin
            gnt  = '0;
            xfer = 1'b0;
        end
        op        = rq.we[sel] ? WRITE : READ;
        wr        = xfer && (op == WRITE);
        rd        = xfer && (op == READ);
        sel_addr  = rq.addr[int'(sel)*ADDR_W +: ADDR_W];
        sel_wdata = rq.wdata[int'(sel)*DATA_W +: DATA_W];
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        pipe_vld_d = pipe_vld_q;
        pipe_id_d  = pipe_id_q;
        for (int s = READ_LATENCY - 1; s > 0; s--) begin
            pipe_vld_d[s] = pipe_vld_q[s-1];
            pipe_id_d[s]  = pipe_id_q[s-1];
        end
        pipe_vld_d[0] = rd;
        pipe_id_d[0]  = sel;

        if (xfer) begin
            rr_ptr_d = PTR_W'(wrap_inc(32'(sel), NUM_REQ));
            if (rq.lock[sel]) begin
                state_d = LOCKED;
                owner_d = sel;
            end else begin
                state_d = IDLE;
            end
            if (wr) begin
                waddr_d = sel_addr;
                wdata_d = sel_wdata;
            end
        end else if (state_q == LOCKED) begin
            // owner let go of req: release without a transfer
            state_d  = IDLE;
            rr_ptr_d = PTR_W'(wrap_inc(32'(owner_q), NUM_REQ));
        end
    end

    always_comb begin
        rq.gnt        = gnt;
        rq.rdata      = mem.mem_rdata;
        rq.busy       = !rst && ((state_q == LOCKED) || (|pipe_vld_q));
        rq.rvalid     = '0;
        if (!rst && pipe_vld_q[READ_LATENCY-1]) begin
            rq.rvalid[pipe_id_q[READ_LATENCY-1]] = 1'b1;
        end
        mem.mem_we    = wr;
        mem.mem_waddr = wr ? sel_addr : waddr_q;
        mem.mem_wdata = wr ? sel_wdata : wdata_q;
        mem.mem_raddr = sel_addr;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            pipe_vld_q <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            pipe_vld_q <= pipe_vld_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
        pipe_id_q <= pipe_id_d;
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios then random traffic, all
// compared each cycle against a transaction-level model of grants and reads.
module tb_sram_port_arbiter;

    localparam int NR = 4;
    localparam int AW = 16;
    localparam int DW = 128;
    localparam int RL = 2;

    logic clock;
    logic rst;

    sram_port_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) rq ();
    sram_mem_if #(.ADDR_W(AW), .DATA_W(DW)) mem ();

    sram_port_arbiter #(
        .NUM_REQ      (NR),
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .READ_LATENCY (RL)
    ) dut (
        .clock (clock),
        .rst   (rst),
        .rq    (rq),
        .mem   (mem)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // SRAM stand-in: read captures the pre-write contents, data appears RL clocks later
    logic [DW-1:0] sram [65536];
    logic [DW-1:0] rd_pipe [RL];
    always @(posedge clock) begin
        rd_pipe[0] <= sram[mem.mem_raddr];
        for (int s = 1; s < RL; s++) rd_pipe[s] <= rd_pipe[s-1];
        if (mem.mem_we) sram[mem.mem_waddr] <= mem.mem_wdata;
    end
    assign mem.mem_rdata = rd_pipe[RL-1];

    typedef struct {
        int            due;
        int            id;
        bit            known;
        logic [DW-1:0] data;
    } rd_t;

    int            n_chk;
    int            n_fail;
    int            cyc;
    int            m_rr;
    int            m_owner;
    rd_t           pend[$];
    logic [DW-1:0] model_mem [int];

    bit            rst_v;
    logic [NR-1:0] req_v, we_v, lock_v;
    logic [AW-1:0] a_v [NR];
    logic [DW-1:0] d_v [NR];

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h, want %0h", tag, cyc, act, exp);
        end
    endtask

    task automatic step(input logic [NR-1:0] lit_gnt, input bit use_lit);
        int            w;
        bit            pop;
        logic [NR-1:0] e_gnt, e_rvalid;
        rd_t           t;
        rst     = rst_v;
        rq.req  = req_v;
        rq.we   = we_v;
        rq.lock = lock_v;
        for (int i = 0; i < NR; i++) begin
            rq.addr[i*AW +: AW]  = a_v[i];
            rq.wdata[i*DW +: DW] = d_v[i];
        end
        @(negedge clock);
        if (rst_v) begin
            chk("rst_gnt", DW'(rq.gnt), '0);
            chk("rst_mem_we", DW'(mem.mem_we), '0);
            chk("rst_rvalid", DW'(rq.rvalid), '0);
            chk("rst_busy", DW'(rq.busy), '0);
            m_rr    = 0;
            m_owner = -1;
            pend.delete();
        end else begin
            w = -1;
            if (m_owner >= 0) begin
                if (req_v[m_owner]) w = m_owner;
            end else begin
                for (int k = 0; k < NR; k++)
                    if (w < 0 && req_v[(m_rr + k) % NR]) w = (m_rr + k) % NR;
            end
            e_gnt    = (w >= 0) ? NR'(1 << w) : '0;
            pop      = (pend.size() > 0) && (pend[0].due == cyc);
            e_rvalid = pop ? NR'(1 << pend[0].id) : '0;
            chk("gnt", DW'(rq.gnt), DW'(e_gnt));
            chk("rvalid", DW'(rq.rvalid), DW'(e_rvalid));
            chk("busy", DW'(rq.busy), DW'((m_owner >= 0) || (pend.size() > 0)));
            if (pop && pend[0].known) chk("rdata", rq.rdata, pend[0].data);
            if (pop) void'(pend.pop_front());
            chk("mem_we", DW'(mem.mem_we), DW'(w >= 0 && we_v[w]));
            if (w >= 0 && we_v[w]) begin
                chk("mem_waddr", DW'(mem.mem_waddr), DW'(a_v[w]));
                chk("mem_wdata", mem.mem_wdata, d_v[w]);
                model_mem[int'(a_v[w])] = d_v[w];
            end
            if (w >= 0 && !we_v[w]) begin
                chk("mem_raddr", DW'(mem.mem_raddr), DW'(a_v[w]));
                t.due   = cyc + RL;
                t.id    = w;
                t.known = model_mem.exists(int'(a_v[w]));
                t.data  = t.known ? model_mem[int'(a_v[w])] : '0;
                pend.push_back(t);
            end
            if (w >= 0) begin
                m_rr    = (w + 1) % NR;
                m_owner = lock_v[w] ? w : -1;
            end else if (m_owner >= 0) begin
                m_rr    = (m_owner + 1) % NR;
                m_owner = -1;
            end
        end
        if (use_lit) chk("lit_gnt", DW'(rq.gnt), DW'(lit_gnt));
        cyc++;
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        cyc     = 0;
        m_rr    = 0;
        m_owner = -1;
        rst_v   = 1'b1;
        req_v   = '0;
        we_v    = '0;
        lock_v  = '0;
        for (int i = 0; i < NR; i++) begin
            a_v[i] = '0;
            d_v[i] = '0;
        end
        rst     = 1'b1;
        rq.req  = '0;
        rq.we   = '0;
        rq.lock = '0;
        rq.addr = '0;
        rq.wdata = '0;
        @(posedge clock);
        #1;

        // reset held with everyone requesting
        req_v = 4'b1111;
        we_v  = 4'b1111;
        repeat (3) step(4'b0000, 1'b1);
        rst_v = 1'b0;

        // round-robin writes
        for (int i = 0; i < NR; i++) begin
            a_v[i] = AW'(16'h0010 + i);
            d_v[i] = {$urandom, $urandom, $urandom, $urandom};
        end
        for (int k = 0; k < 8; k++) step(NR'(1 << (k % NR)), 1'b1);
        for (int i = 0; i < NR; i++) chk("sram_rr", sram[16'h0010 + i], d_v[i]);

        // write then read back through requester 2
        req_v  = 4'b0100;
        we_v   = 4'b0100;
        a_v[2] = 16'h1234;
        d_v[2] = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
        step(4'b0100, 1'b1);
        we_v = 4'b0000;
        step(4'b0100, 1'b1);
        req_v = 4'b0000;
        repeat (RL) step(4'b0000, 1'b1);

        // back-to-back reads by 3 then 0
        req_v  = 4'b1001;
        a_v[0] = 16'h0010;
        a_v[3] = 16'h0013;
        step(4'b1000, 1'b1);
        step(4'b0001, 1'b1);
        req_v = 4'b0000;
        repeat (RL + 1) step(4'b0000, 1'b1);

        // lock burst by requester 1
        req_v  = 4'b1111;
        we_v   = 4'b1111;
        lock_v = 4'b0010;
        repeat (3) step(4'b0010, 1'b1);
        lock_v = 4'b0000;
        step(4'b0010, 1'b1);
        step(4'b0100, 1'b1);

        // requester 3 locks then drops its request
        req_v  = 4'b1000;
        lock_v = 4'b1000;
        step(4'b1000, 1'b1);
        req_v  = 4'b0111;
        lock_v = 4'b0000;
        step(4'b0000, 1'b1);
        step(4'b0001, 1'b1);

        // reset while locked with two reads in flight
        req_v  = 4'b0010;
        we_v   = 4'b0000;
        lock_v = 4'b0010;
        step(4'b0010, 1'b1);
        step(4'b0010, 1'b1);
        rst_v = 1'b1;
        step(4'b0000, 1'b1);
        rst_v  = 1'b0;
        req_v  = 4'b0000;
        lock_v = 4'b0000;
        repeat (4) step(4'b0000, 1'b1);
        req_v = 4'b1111;
        we_v  = 4'b1111;
        step(4'b0001, 1'b1);

        // single requester, then pointer must sit at 3
        req_v = 4'b0100;
        repeat (6) step(4'b0100, 1'b1);
        req_v = 4'b1111;
        step(4'b1000, 1'b1);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            rst_v = ($urandom_range(0, 99) == 0);
            req_v = NR'($urandom);
            we_v  = NR'($urandom);
            for (int i = 0; i < NR; i++) begin
                lock_v[i] = ($urandom_range(0, 3) == 0);
                a_v[i]    = AW'($urandom_range(0, 7));
                d_v[i]    = {$urandom, $urandom, $urandom, $urandom};
            end
            step(4'b0000, 1'b0);
        end
        rst_v = 1'b0;
        req_v = 4'b0000;
        repeat (RL + 1) step(4'b0000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
